// File: rtl/snn_pkg.sv
// +--------------------------------------------------------------------------+
// | snn_pkg                                                                  |
// | Shared state encoding and default sizing for the spike volley encoder.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package snn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int c_default_time_period       = 8;
   localparam int c_default_neurons_per_layer = 8;

   // Width of the externally visible time step, one bit wider than the counter.
   function automatic int time_val_width(input int period);
      return $clog2(period) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/time_counter.sv
// +--------------------------------------------------------------------------+
// | time_counter                                                             |
// | Clearable, enabled step counter that saturates at TIME_PERIOD-1.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module time_counter
   import snn_pkg::*;
#(
   parameter int TIME_PERIOD = c_default_time_period
)
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           enable,
   output logic [$clog2(TIME_PERIOD)-1:0] count,
   output logic [$clog2(TIME_PERIOD)-1:0] count_next,
   output logic                           terminal
);

   localparam int CW = $clog2(TIME_PERIOD);
   localparam logic [CW-1:0] c_last_step = CW'(TIME_PERIOD - 1);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic          w_terminal;

   assign w_terminal = (r_count == c_last_step);

   // Holding at the last step rather than wrapping keeps a stuck enable harmless.
   always_comb begin
      w_count_next = r_count;
      if (clear) begin
         w_count_next = '0;
      end else if (enable && !w_terminal) begin
         w_count_next = r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign count      = r_count;
   assign count_next = w_count_next;
   assign terminal   = w_terminal;

endmodule

`default_nettype wire

// File: rtl/spike_volley_encoder.sv
// +--------------------------------------------------------------------------+
// | spike_volley_encoder                                                     |
// | Converts per-neuron spike times into a volley of registered one-cycle    |
// | pulses. Define EARLY_STOP_EN to let inhibit cut a volley short.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module spike_volley_encoder
   import snn_pkg::*;
#(
   parameter int TIME_PERIOD       = c_default_time_period,
   parameter int NEURONS_PER_LAYER = c_default_neurons_per_layer
)
(
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic [NEURONS_PER_LAYER-1:0][$clog2(TIME_PERIOD)-1:0] in_times,
   input  logic [NEURONS_PER_LAYER-1:0]                        in_mask,
   input  logic                                                inhibit,
   output logic [NEURONS_PER_LAYER-1:0]                        spike_volley,
   output logic [time_val_width(TIME_PERIOD)-1:0]              time_val,
   output logic                                                busy,
   output logic                                                done
);

   localparam int CW = $clog2(TIME_PERIOD);

   state_t                              r_state;
   logic [NEURONS_PER_LAYER-1:0][CW-1:0] r_times;
   logic [NEURONS_PER_LAYER-1:0]         r_mask;
   logic [NEURONS_PER_LAYER-1:0]         r_spike_volley;
   logic                                 r_in_ready;
   logic                                 r_busy;
   logic                                 r_done;

   logic [NEURONS_PER_LAYER-1:0][CW-1:0] w_times_src;
   logic [NEURONS_PER_LAYER-1:0]         w_mask_src;
   logic [NEURONS_PER_LAYER-1:0]         w_match;
   logic [CW-1:0]                        w_count;
   logic [CW-1:0]                        w_count_next;
   logic                                 w_terminal;
   logic                                 w_accept;
   logic                                 w_stop;
   logic                                 w_clear;
   logic                                 w_enable;

   assign w_accept = in_valid & r_in_ready;

`ifdef EARLY_STOP_EN
   assign w_stop = inhibit & (r_state == RUN);
`else
   logic w_inhibit_unused;
   assign w_inhibit_unused = inhibit;
   assign w_stop           = 1'b0;
`endif

   // The counter reads zero everywhere outside RUN, so time_val needs no gating.
   assign w_clear  = (r_state != RUN) | w_terminal | w_stop;
   assign w_enable = (r_state == RUN);

   time_counter #(
      .TIME_PERIOD (TIME_PERIOD)
   ) u_time_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (w_clear),
      .enable     (w_enable),
      .count      (w_count),
      .count_next (w_count_next),
      .terminal   (w_terminal)
   );

   // Pulses are registered, so they are matched against the step the counter
   // is about to show; on the accepting edge the pattern is still on the inputs.
   assign w_times_src = (r_state == IDLE) ? in_times : r_times;
   assign w_mask_src  = (r_state == IDLE) ? in_mask  : r_mask;

   for (genvar i = 0; i < NEURONS_PER_LAYER; i++) begin : g_neuron
      assign w_match[i] = w_mask_src[i] & (w_times_src[i] == w_count_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_times        <= '0;
         r_mask         <= '0;
         r_spike_volley <= '0;
         r_in_ready     <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_spike_volley <= '0;
         r_done         <= 1'b0;
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_state        <= RUN;
                  r_times        <= in_times;
                  r_mask         <= in_mask;
                  r_spike_volley <= w_match;
                  r_busy         <= 1'b1;
                  r_in_ready     <= 1'b0;
               end
            end
            RUN: begin
               if (w_terminal || w_stop) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_spike_volley <= w_match;
               end
            end
            DONE: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b1;
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign spike_volley = r_spike_volley;
   assign time_val     = {1'b0, w_count};
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spike_volley_encoder.sv
// +--------------------------------------------------------------------------+
// | tb_spike_volley_encoder                                                  |
// | Self-checking bench: vector table, scoreboard queue, corner sequences.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spike_volley_encoder;

   localparam int TP  = 8;
   localparam int NPL = 8;
   localparam int CW  = 3;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [NPL-1:0][CW-1:0] in_times;
   logic [NPL-1:0]         in_mask;
   logic                   inhibit;
   logic [NPL-1:0]         spike_volley;
   logic [CW:0]            time_val;
   logic                   busy;
   logic                   done;

   typedef struct packed {
      logic [NPL-1:0] spike;
      logic [CW:0]    tv;
      logic           busy;
      logic           done;
      logic           rdy;
   } obs_t;

   typedef struct {
      logic [NPL-1:0][CW-1:0] times;
      logic [NPL-1:0]         mask;
      int                     inh_step;
      logic                   idle_inh;
   } vec_t;

   obs_t exp_q[$];
   obs_t mon_act;
   obs_t mon_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   spike_volley_encoder #(
      .TIME_PERIOD       (TP),
      .NEURONS_PER_LAYER (NPL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_times     (in_times),
      .in_mask      (in_mask),
      .inhibit      (inhibit),
      .spike_volley (spike_volley),
      .time_val     (time_val),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int stop_of(input int inh_step);
`ifdef EARLY_STOP_EN
      return inh_step;
`else
      return -1;
`endif
   endfunction

   // Reference model: one record per RUN cycle, then the DONE cycle.
   task automatic push_volley(input logic [NPL-1:0][CW-1:0] times, input logic [NPL-1:0] mask,
                              input int stop);
      for (int c = 0; c < TP; c++) begin
         logic [NPL-1:0] s;
         s = '0;
         for (int i = 0; i < NPL; i++) begin
            if (mask[i] && times[i] == CW'(c)) s[i] = 1'b1;
         end
         exp_q.push_back('{s, 4'(c), 1'b1, 1'b0, 1'b0});
         if (c == stop) break;
      end
      exp_q.push_back('{'0, 4'd0, 1'b0, 1'b1, 1'b0});
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
         mon_act = '{spike_volley, time_val, busy, done, in_ready};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL volley_unexpected: got spike=%h tv=%0d busy=%b done=%b rdy=%b, expected idle",
                     mon_act.spike, mon_act.tv, mon_act.busy, mon_act.done, mon_act.rdy);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               n_fail++;
               $display("FAIL volley_cycle: got spike=%h tv=%0d busy=%b done=%b rdy=%b, expected spike=%h tv=%0d busy=%b done=%b rdy=%b",
                        mon_act.spike, mon_act.tv, mon_act.busy, mon_act.done, mon_act.rdy,
                        mon_exp.spike, mon_exp.tv, mon_exp.busy, mon_exp.done, mon_exp.rdy);
            end
         end
      end
   end

   task automatic start_vol(input vec_t v);
      int k;
      k = 0;
      inhibit = v.idle_inh;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("ready_wait", {31'd0, in_ready}, 32'd1);
      in_times = v.times;
      in_mask  = v.mask;
      in_valid = 1'b1;
      push_volley(v.times, v.mask, stop_of(v.inh_step));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inhibit  = 1'b0;
      in_times = ~v.times;
      in_mask  = ~v.mask;
   endtask

   task automatic finish_vol(input vec_t v);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         inhibit = (busy && time_val == 4'(v.inh_step)) ? 1'b1 : 1'b0;
         k++;
      end while (!done && k < 40);
      check("done_seen", {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
      inhibit = 1'b0;
      check("queue_drained", exp_q.size(), 32'd0);
      check("ready_after_done", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;
      int   acc[3];
      int   n;
      int   cyc;
      int   k;

      for (int t = 0; t < 8; t++) begin
         tbl[t].inh_step = -1;
         tbl[t].idle_inh = 1'b0;
      end
      for (int i = 0; i < NPL; i++) begin
         tbl[0].times[i] = CW'(i);
         tbl[1].times[i] = 3'd3;
         tbl[2].times[i] = CW'(i);
         tbl[3].times[i] = CW'(7 - i);
         tbl[4].times[i] = 3'd7;
         tbl[5].times[i] = (i % 2 == 1) ? 3'd0 : 3'd7;
         tbl[6].times[i] = CW'(i);
         tbl[7].times[i] = CW'(i);
      end
      tbl[0].mask = 8'hFF;
      tbl[1].mask = 8'hA5;
      tbl[2].mask = 8'h00;
      tbl[3].mask = 8'h5A;
      tbl[4].mask = 8'h81;
      tbl[5].mask = 8'hFF;
      tbl[6].mask = 8'hFF;
      tbl[6].inh_step = 2;
      tbl[6].idle_inh = 1'b1;
      tbl[7].mask = 8'hFF;
      tbl[7].inh_step = 7;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      inhibit  = 1'b0;
      in_times = '0;
      in_mask  = '0;
      #3;
      check("reset_outputs", {17'd0, spike_volley, time_val, busy, done, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("reset_held", {17'd0, spike_volley, time_val, busy, done, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_first_edge", {31'd0, in_ready}, 32'd1);

      for (int t = 0; t < 8; t++) begin
         start_vol(tbl[t]);
         finish_vol(tbl[t]);
      end

      // in_valid held high: accepts must be TP+2 cycles apart.
      v = tbl[3];
      in_times = v.times;
      in_mask  = v.mask;
      in_valid = 1'b1;
      n   = 0;
      cyc = 0;
      acc = '{0, 0, 0};
      while (n < 3 && cyc < 60) begin
         @(negedge clk);
         if (in_ready) begin
            push_volley(v.times, v.mask, -1);
            acc[n] = cyc;
            n++;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("cont_transfers", n, 32'd3);
      check("cont_spacing_1", acc[1] - acc[0], 32'd10);
      check("cont_spacing_2", acc[2] - acc[1], 32'd10);
      finish_vol(v);

      // Reset mid-volley at time_val=4.
      start_vol(tbl[0]);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (time_val != 4'd4 && k < 20);
      check("reach_tv4", {28'd0, time_val}, 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {17'd0, spike_volley, time_val, busy, done, in_ready}, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("abort_held", {17'd0, spike_volley, time_val, busy, done, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_low_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_release", {31'd0, in_ready}, 32'd1);
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
      start_vol(tbl[1]);
      finish_vol(tbl[1]);

      check("queue_empty_end", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/spike_volley_encoder.md
SPIKE_VOLLEY_ENCODER -- requirements
Module: spike_volley_encoder

Interface
REQ-001 Parameter TIME_PERIOD, default 8: number of time steps per volley; power of two, at least 2.
REQ-002 Parameter NEURONS_PER_LAYER, default 8: number of spike lines in the volley.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: the pattern on in_times and in_mask is offered.
REQ-006 Port in_ready, output, 1: the encoder can accept a pattern.
REQ-007 Port in_times, input, NEURONS_PER_LAYER x $clog2(TIME_PERIOD): spike time per neuron.
REQ-008 Port in_mask, input, NEURONS_PER_LAYER: 1 means the neuron spikes; 0 means it stays silent for the whole volley.
REQ-009 Port inhibit, input, 1: a winner has been found downstream; used only when EARLY_STOP_EN is defined.
REQ-010 Port spike_volley, output, NEURONS_PER_LAYER: registered one-cycle spike pulses.
REQ-011 Port time_val, output, $clog2(TIME_PERIOD)+1: current time step; same width as the inhibition stage's time input.
REQ-012 Port busy, output, 1: high in RUN.
REQ-013 Port done, output, 1: one-cycle pulse at the end of a volley.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-016 On a transfer, in_times and in_mask SHALL be latched, the counter cleared to 0 and the state set to RUN.
REQ-017 The cycle after a transfer SHALL show time_val=0; in RUN, time_val SHALL increment by 1 per cycle up to TIME_PERIOD-1.
REQ-018 In RUN, spike_volley[i] SHALL be 1 exactly when the latched mask[i] is 1 and the latched time[i] equals time_val; otherwise 0.
REQ-019 A neuron SHALL spike at most once per volley; several neurons MAY spike in the same cycle.
REQ-020 After the cycle where time_val=TIME_PERIOD-1, the state SHALL go to DONE for exactly one cycle; done=1 in that cycle, then IDLE.
REQ-021 In IDLE and DONE, spike_volley SHALL be 0, time_val SHALL be 0 and busy SHALL be 0.
REQ-022 in_valid in DONE SHALL NOT be accepted; the minimum spacing from one transfer to the next is TIME_PERIOD+2 cycles.
REQ-023 Input changes while in RUN or DONE SHALL NOT affect the volley in progress.
REQ-024 The counter SHALL NOT wrap; time_val never reaches TIME_PERIOD.

Reset
REQ-025 When rst_n is low, the block SHALL asynchronously force IDLE and clear the counter, latched times and latched mask.
REQ-026 During reset, outputs SHALL be spike_volley=0, time_val=0, busy=0, done=0 and in_ready=0.
REQ-027 Reset mid-RUN SHALL abort the volley with no done pulse.
REQ-028 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro EARLY_STOP_EN, when defined: inhibit=1 in RUN SHALL force spike_volley=0 from the next cycle and move the state to DONE on that edge.
REQ-030 With EARLY_STOP_EN defined: inhibit on the final RUN cycle SHALL give the normal DONE; inhibit outside RUN SHALL have no effect.
REQ-031 Without EARLY_STOP_EN, the inhibit port SHALL still exist and SHALL be ignored.

Structure
REQ-032 Package snn_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default TIME_PERIOD and NEURONS_PER_LAYER constants.
REQ-033 Sub-module time_counter SHALL hold the clearable, enabled step counter, with a terminal-count output at TIME_PERIOD-1; the rest stays in spike_volley_encoder.

Verification
REQ-034 Scenario: times={0,1,...,7}, mask=0xFF -> spike_volley=0x01,0x02,...,0x80 on consecutive cycles with time_val 0..7, then one done pulse.
REQ-035 Scenario: all times=3, mask=0xA5 -> a single pulse 0xA5 at time_val=3, zeros elsewhere; done 9 cycles after the transfer.
REQ-036 Scenario: mask=0x00 -> a full 8-cycle RUN with spike_volley all zero, then done.
REQ-037 Scenario: in_valid held high continuously -> transfers exactly 10 cycles apart; no accept while in RUN or DONE.
REQ-038 Scenario: rst_n pulsed low at time_val=4 -> outputs zero immediately, no done pulse, in_ready=1 after release.
REQ-039 Scenario, EARLY_STOP_EN defined: inhibit at time_val=2 -> volley zero from the next cycle and done that cycle; with the macro undefined, the full 8-step volley.
